// File: rtl/vga_640x480.sv
// VGA 640x480@60Hz timing generator: divides i_clk down to the pixel clock and produces
// registered pixel/line counters plus combinationally decoded syncs and active flag.
module vga_640x480 #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       pix_clk
);

    localparam int unsigned DivW = $clog2(CLK_DIV);

    localparam logic [9:0] HMax       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VMax       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            tick;

    // Tick coincides with the divider wrap, i.e. the falling edge of pix_clk.
    assign tick = (div_q == DivLast);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == HMax) begin
                x_d = '0;
                if (y_q == VMax) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign pix_clk  = div_q[DivW-1];
    assign o_x      = x_q;
    assign o_y      = y_q;
    assign o_hsync  = !((x_q >= HSyncStart) && (x_q <= HSyncEnd));
    assign o_vsync  = !((y_q >= VSyncStart) && (y_q <= VSyncEnd));
    // Gated by reset so active drops immediately, independent of the counters.
    assign o_active = i_rst && (x_q < HActive) && (y_q < VActive);

endmodule

// File: tb/tb_vga_640x480.sv
// Directed bench for vga_640x480: full-size instance for reset/line timing and a
// reduced-geometry instance so whole frames fit in a short run.
module tb_vga_640x480;

    logic       i_clk;
    logic       i_rst;
    logic       hs_a, vs_a, act_a, pix_a;
    logic [9:0] x_a, y_a;

    logic       rst_b;
    logic       hs_b, vs_b, act_b, pix_b;
    logic [9:0] x_b, y_b;

    int vectors     = 0;
    int miscompares = 0;

    vga_640x480 u_dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .o_hsync  (hs_a),
        .o_vsync  (vs_a),
        .o_x      (x_a),
        .o_y      (y_a),
        .o_active (act_a),
        .pix_clk  (pix_a)
    );

    // 24 x 13 total, active 16 x 8, hsync x=18..21, vsync y=9..10, 2 clocks per pixel.
    vga_640x480 #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .CLK_DIV  (2)
    ) u_small (
        .i_clk    (i_clk),
        .i_rst    (rst_b),
        .o_hsync  (hs_b),
        .o_vsync  (vs_b),
        .o_x      (x_b),
        .o_y      (y_b),
        .o_active (act_b),
        .pix_clk  (pix_b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic       p_pix, p_hs, p_act;
        logic [9:0] p_x, p_y;
        int         highs, bad_x, n;
        int         hs_fall_x, hs_rise_x, hs_low, act_fall_x, act_rise_x, wrap_y, wraps;
        int         vs_low, vs_bad, act_bad, wrap_ok, wrap_bad, rises, distinct;
        bit         seen [0:311];

        i_rst = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("rst_x", 32'(x_a), 0);
        chk("rst_y", 32'(y_a), 0);
        chk("rst_hsync", 32'(hs_a), 1);
        chk("rst_vsync", 32'(vs_a), 1);
        chk("rst_active", 32'(act_a), 0);
        chk("rst_pixclk", 32'(pix_a), 0);

        i_rst = 1'b1;
        #1;
        chk("release_active", 32'(act_a), 1);
        repeat (3) @(negedge i_clk);
        chk("x_before_tick", 32'(x_a), 0);
        chk("pix_high_div3", 32'(pix_a), 1);
        @(negedge i_clk);
        chk("x_first_tick", 32'(x_a), 1);
        chk("pix_low_div0", 32'(pix_a), 0);

        // 36 more cycles -> 40 since release.
        highs = 0;
        bad_x = 0;
        p_pix = pix_a;
        p_x   = x_a;
        repeat (36) begin
            @(negedge i_clk);
            if (pix_a) highs++;
            if ((x_a != p_x) && !(p_pix && !pix_a)) bad_x++;
            p_pix = pix_a;
            p_x   = x_a;
        end
        chk("pix_high_cycles", 32'(highs), 18);
        chk("x_change_off_fall", 32'(bad_x), 0);
        chk("x_after_40", 32'(x_a), 10);

        // One full line: x=10 -> wrap -> x=10 on the next line.
        hs_fall_x = -1; hs_rise_x = -1; hs_low = 0;
        act_fall_x = -1; act_rise_x = -1; wrap_y = -1; wraps = 0;
        p_hs = hs_a; p_act = act_a; p_x = x_a;
        repeat (3200) begin
            @(negedge i_clk);
            if (!hs_a) hs_low++;
            if (p_hs && !hs_a) hs_fall_x = int'(x_a);
            if (!p_hs && hs_a) hs_rise_x = int'(x_a);
            if (p_act && !act_a) act_fall_x = int'(x_a);
            if (!p_act && act_a) act_rise_x = int'(x_a);
            if (p_x == 10'd799 && x_a == 10'd0) begin
                wrap_y = int'(y_a);
                wraps++;
            end
            p_hs = hs_a; p_act = act_a; p_x = x_a;
        end
        chk("hsync_fall_x", 32'(hs_fall_x), 656);
        chk("hsync_rise_x", 32'(hs_rise_x), 752);
        chk("hsync_low_clks", 32'(hs_low), 384);
        chk("active_fall_x", 32'(act_fall_x), 640);
        chk("active_rise_x", 32'(act_rise_x), 0);
        chk("line_wraps", 32'(wraps), 1);
        chk("wrap_y", 32'(wrap_y), 1);
        chk("line_end_x", 32'(x_a), 10);
        chk("vsync_line1", 32'(vs_a), 1);

        // Asynchronous reset mid-line with divider at 2.
        n = 0;
        while (x_a != 10'd300 && n < 4000) begin
            @(negedge i_clk);
            n++;
        end
        chk("reach_x300", 32'(x_a), 300);
        repeat (2) @(negedge i_clk);
        chk("mid_pix_div2", 32'(pix_a), 1);
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_x", 32'(x_a), 0);
        chk("async_y", 32'(y_a), 0);
        chk("async_active", 32'(act_a), 0);
        chk("async_pix", 32'(pix_a), 0);
        chk("async_hsync", 32'(hs_a), 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("restart_x", 32'(x_a), 1);
        chk("restart_y", 32'(y_a), 0);

        // Reduced-geometry frames: frame = 24*13*2 = 624 clocks.
        rst_b = 1'b1;
        vs_low = 0; vs_bad = 0; act_bad = 0; wrap_ok = 0; wrap_bad = 0;
        rises = 0; distinct = 0;
        for (int i = 0; i < 312; i++) seen[i] = 1'b0;
        p_x = x_b; p_y = y_b; p_pix = pix_b;
        for (int c = 1; c <= 1252; c++) begin
            @(negedge i_clk);
            if (c <= 624 && !vs_b) vs_low++;
            if (!vs_b != (y_b == 10'd9 || y_b == 10'd10)) vs_bad++;
            if (act_b && (y_b >= 10'd8 || x_b >= 10'd16)) act_bad++;
            if (p_y == 10'd12 && y_b == 10'd0) begin
                if (p_x == 10'd23 && x_b == 10'd0) wrap_ok++;
                else wrap_bad++;
            end
            if (c <= 624 && !p_pix && pix_b) begin
                rises++;
                if (x_b < 10'd24 && y_b < 10'd13 && !seen[int'(y_b) * 24 + int'(x_b)]) begin
                    seen[int'(y_b) * 24 + int'(x_b)] = 1'b1;
                    distinct++;
                end
            end
            p_x = x_b; p_y = y_b; p_pix = pix_b;
        end
        chk("vsync_low_clks", 32'(vs_low), 96);
        chk("vsync_wrong_y", 32'(vs_bad), 0);
        chk("active_outside", 32'(act_bad), 0);
        chk("frame_wraps", 32'(wrap_ok), 2);
        chk("frame_wrap_bad", 32'(wrap_bad), 0);
        chk("pix_rises_frame", 32'(rises), 312);
        chk("distinct_xy", 32'(distinct), 312);
        chk("small_end_x", 32'(x_b), 2);
        chk("small_end_y", 32'(y_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
